// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock meter.
package clk_meter_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

endpackage

// File: rtl/clk_meter_sync.sv
// Synchronizer chain plus edge register for the measured clock.
// rise_o/fall_o are single-cycle strobes derived from the last sync stage.
module clk_meter_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic meas_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift meas_i through the synchronizer and remember the previous synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge strobes from synced level versus previous level
  always_comb begin
    rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

endmodule

// File: rtl/clk_meter.sv
// Clock meter: measures period, high time and (optionally) phase of an
// asynchronous clock against clk. Optional phase logic: CLK_METER_PHASE_EN.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             start,
  input  logic             ref_pulse,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_hit,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             ovf_q, ovf_d;
  logic             rise, fall;
  logic             accept;
  logic             cnt_sat;

  clk_meter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .meas_i(meas_in),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Start is honoured only when not busy (IDLE, or DONE where busy is already low)
  always_comb begin
    accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    cnt_sat = (cnt_q == CNT_MAX);
  end

  // FSM state and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, counter and capture logic; saturation takes priority over edges
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    ovf_d      = ovf_q;
    busy       = 1'b0;
    meas_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ARM;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ARM: begin
        busy = 1'b1;
        if (cnt_sat) begin
          state_d  = ST_DONE;
          ovf_d    = 1'b1;
          period_d = '1;
          high_d   = '1;
        end else if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        busy = 1'b1;
        if (cnt_sat) begin
          state_d  = ST_DONE;
          ovf_d    = 1'b1;
          period_d = '1;
          high_d   = '1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            high_d  = cnt_q;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        busy = 1'b1;
        if (cnt_sat) begin
          state_d  = ST_DONE;
          ovf_d    = 1'b1;
          period_d = '1;
        end else if (rise) begin
          period_d = cnt_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        meas_valid = 1'b1;
        if (accept) begin
          state_d = ST_ARM;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result outputs are the capture registers
  always_comb begin
    period_cnt = period_q;
    high_cnt   = high_q;
    ovf        = ovf_q;
  end

`ifdef CLK_METER_PHASE_EN
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             hit_q, hit_d;

  // Phase counter and hit flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hit_q   <= hit_d;
    end
  end

  // Counting runs through the rise-detect cycle, so a ref_pulse coincident
  // with the rise reads 0 and each earlier cycle adds one
  always_comb begin
    phase_d = phase_q;
    hit_d   = hit_q;
    if (accept) begin
      phase_d = '0;
      hit_d   = 1'b0;
    end else if (state_q == ST_ARM) begin
      if (!hit_q && ref_pulse) begin
        hit_d   = 1'b1;
        phase_d = '0;
      end else if (hit_q && phase_q != CNT_MAX) begin
        phase_d = phase_q + CNT_ONE;
      end
    end
  end

  // Phase outputs
  always_comb begin
    phase_cnt = phase_q;
    phase_hit = hit_q;
  end
`else
  logic unused_ref_pulse;

  // Phase logic omitted: ports tied low, ref_pulse ignored
  always_comb begin
    unused_ref_pulse = ref_pulse;
    phase_cnt        = '0;
    phase_hit        = 1'b0;
  end
`endif

endmodule

// File: tb/tb_clk_meter.sv
// Self-checking bench for clk_meter: randomized waveforms against an
// arithmetic reference model of period, high time, phase and latency.
module tb_clk_meter;

  localparam int unsigned CW = 8;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          meas_in;
  logic          start;
  logic          ref_pulse;
  logic          busy;
  logic          meas_valid;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] phase_cnt;
  logic          phase_hit;
  logic          ovf;

  clk_meter #(
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .meas_in   (meas_in),
    .start     (start),
    .ref_pulse (ref_pulse),
    .busy      (busy),
    .meas_valid(meas_valid),
    .period_cnt(period_cnt),
    .high_cnt  (high_cnt),
    .phase_cnt (phase_cnt),
    .phase_hit (phase_hit),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Snapshot of outputs at each meas_valid strobe
  int unsigned   nvalid;
  int unsigned   vcyc;
  logic [CW-1:0] vper, vhigh, vph;
  logic          vhit, vovf, vbusy;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      nvalid = nvalid + 1;
      vcyc   = cyc;
      vper   = period_cnt;
      vhigh  = high_cnt;
      vph    = phase_cnt;
      vhit   = phase_hit;
      vovf   = ovf;
      vbusy  = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected phase: first in-ARM ref at offset R, rise first sampled at offset P,
  // detected SS edges later; ARM spans edges 1..P+SS after acceptance.
  task automatic exp_phase(input int P, input int R, output int ph, output int hit);
    ph  = 0;
    hit = 0;
`ifdef CLK_METER_PHASE_EN
    if (R >= 1 && R <= P + int'(SS)) begin
      hit = 1;
      ph  = P + int'(SS) - R;
    end
`endif
  endtask

  // One measurement: low lead-in P, high H, low L, then high; first ref at R (0 = none).
  // With noise, start is re-pulsed while busy and stray refs arrive after the rise.
  task automatic run_meas(input int P, input int H, input int L, input int R,
                          input bit noise, input string nm);
    int unsigned a;
    int total, eph, ehit;
    nvalid = 0;
    @(posedge clk); #1;
    start = 1'b1; meas_in = 1'b0; ref_pulse = 1'b0;
    a = cyc + 1;
    total = P + H + L + int'(SS) + 3;
    for (int k = 1; k <= total; k++) begin
      @(posedge clk); #1;
      if (k == P + int'(SS) + 2) chk({nm, "_busy"}, busy, 1);
      start     = noise && (k <= P + H + L + int'(SS)) && ($urandom_range(0, 3) == 0);
      meas_in   = (k >= P && k < P + H) || (k >= P + H + L);
      ref_pulse = (R > 0 && (k == R || k == R + 2)) ||
                  (noise && k > P + int'(SS) && $urandom_range(0, 3) == 0);
    end
    start = 1'b0; ref_pulse = 1'b0;
    exp_phase(P, R, eph, ehit);
    chk({nm, "_nvalid"}, nvalid, 1);
    chk({nm, "_lat"},    vcyc, a + P + H + L + SS);
    chk({nm, "_period"}, vper, H + L);
    chk({nm, "_high"},   vhigh, H);
    chk({nm, "_ovf"},    vovf, 0);
    chk({nm, "_busy_v"}, vbusy, 0);
    chk({nm, "_phase"},  vph, eph);
    chk({nm, "_hit"},    vhit, ehit);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_hold"},   period_cnt, H + L);
  endtask

  initial begin
    int unsigned a;
    int P, H, L, R;
    rst_n = 1'b0; meas_in = 1'b0; start = 1'b0; ref_pulse = 1'b0; nvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   busy, 0);
    chk("rst_valid",  meas_valid, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_high",   high_cnt, 0);
    chk("rst_phase",  phase_cnt, 0);
    chk("rst_hit",    phase_hit, 0);
    chk("rst_ovf",    ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 10 MHz at 30% duty
    run_meas(3, 3, 7, 0, 1'b0, "duty30");
    // ref four cycles before the meas_in rise
    run_meas(5, 4, 6, 1, 1'b0, "phase4");
    // ref coincident with the rise detect
    run_meas(3, 2, 3, 3 + int'(SS), 1'b0, "phase0");

    for (int i = 0; i < 20; i++) begin
      P = int'($urandom_range(1, 8));
      H = int'($urandom_range(1, 20));
      L = int'($urandom_range(1, 20));
      R = int'($urandom_range(0, P + int'(SS) + 3));
      run_meas(P, H, L, R, 1'b1, "rand");
    end

    // Saturation with meas_in held low
    nvalid = 0;
    @(posedge clk); #1;
    start = 1'b1; meas_in = 1'b0;
    a = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ((1 << CW) + 4) @(posedge clk);
    #1;
    chk("sat_nvalid", nvalid, 1);
    chk("sat_lat",    vcyc, a + (1 << CW));
    chk("sat_ovf",    vovf, 1);
    chk("sat_period", vper, (1 << CW) - 1);
    chk("sat_high",   vhigh, (1 << CW) - 1);
    chk("sat_phase",  vph, 0);
    chk("sat_hit",    vhit, 0);
    chk("sat_hold",   ovf, 1);
    run_meas(2, 5, 5, 1, 1'b0, "post_sat");

    // Reset while in HIGH
    nvalid = 0;
    @(posedge clk); #1;
    start = 1'b1; meas_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      meas_in = (k >= 2 && k < 12) || (k >= 17);
      ref_pulse = (k == 1);
      if (k == 2 + int'(SS) + 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   busy, 0);
        chk("mid_rst_valid",  meas_valid, 0);
        chk("mid_rst_period", period_cnt, 0);
        chk("mid_rst_high",   high_cnt, 0);
        chk("mid_rst_phase",  phase_cnt, 0);
        chk("mid_rst_hit",    phase_hit, 0);
        chk("mid_rst_ovf",    ovf, 0);
      end
      if (k == 2 + int'(SS) + 4) rst_n = 1'b1;
    end
    ref_pulse = 1'b0;
    chk("mid_rst_nvalid", nvalid, 0);
    run_meas(4, 6, 9, 2, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
